// File: rtl/mem_arbiter_pkg.sv
// Shared types for mem_arbiter: FSM states, transaction owner codes and
// round-robin slot indices.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_BOOT,
    OWN_INST,
    OWN_DATA
  } owner_e;

  localparam int unsigned RR_INST = 0;
  localparam int unsigned RR_DATA = 1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: on contention the slot not granted last wins.
// The priority pointer moves only when a grant is actually taken (advance).
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // prio_q = 1: data slot wins a tie; reset favours data
  logic prio_q, prio_d;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = prio_q ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (advance && (gnt != '0)) begin
      prio_d = gnt[RR_INST];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= 1'b1;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises boot writes, instruction fetches and data accesses
// onto one SRAM port. Define MEM_ARB_STATS_EN to add per-port grant counters.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 20,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  boot_mode,
  input  logic                  boot_req,
  input  logic [ADDR_WIDTH-1:0] boot_addr,
  input  logic [DATA_WIDTH-1:0] boot_wr_data,
  output logic                  boot_ack,
  input  logic                  inst_req,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  output logic [DATA_WIDTH-1:0] inst_rd_data,
  output logic                  inst_ack,
  input  logic                  data_req,
  input  logic                  data_wr_en,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wr_data,
  output logic [DATA_WIDTH-1:0] data_rd_data,
  output logic                  data_ack,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  busy
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]           inst_grant_cnt,
  output logic [15:0]           data_grant_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(ACCESS_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

  arb_state_e            state_q, state_d;
  owner_e                owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] inst_rd_q, inst_rd_d;
  logic [DATA_WIDTH-1:0] data_rd_q, data_rd_d;

  logic [1:0] rr_req, rr_gnt;
  logic       rr_adv;

  // inst/data only compete outside boot mode, and only while requests are sampled
  assign rr_req = boot_mode ? 2'b00 : {data_req, inst_req};
  assign rr_adv = (state_q == S_IDLE) && !boot_mode;

  rr_pick2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (rr_req),
    .advance (rr_adv),
    .gnt     (rr_gnt)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    cnt_d     = cnt_q;
    inst_rd_d = inst_rd_q;
    data_rd_d = data_rd_q;
    case (state_q)
      S_IDLE: begin
        if (boot_mode && boot_req) begin
          owner_d = OWN_BOOT;
          addr_d  = boot_addr;
          wdata_d = boot_wr_data;
          we_d    = 1'b1;
          state_d = S_ISSUE;
        end else if (rr_gnt[RR_DATA]) begin
          owner_d = OWN_DATA;
          addr_d  = data_addr;
          wdata_d = data_wr_data;
          we_d    = data_wr_en;
          state_d = S_ISSUE;
        end else if (rr_gnt[RR_INST]) begin
          owner_d = OWN_INST;
          addr_d  = inst_addr;
          we_d    = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          if (!we_q && (owner_q == OWN_INST)) inst_rd_d = mem_rd_data;
          if (!we_q && (owner_q == OWN_DATA)) data_rd_d = mem_rd_data;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_BOOT;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      cnt_q     <= '0;
      inst_rd_q <= '0;
      data_rd_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      cnt_q     <= cnt_d;
      inst_rd_q <= inst_rd_d;
      data_rd_q <= data_rd_d;
    end
  end

  assign mem_rd_en    = (state_q == S_ISSUE) && !we_q;
  assign mem_wr_en    = (state_q == S_ISSUE) && we_q;
  assign mem_addr     = addr_q;
  assign mem_wr_data  = wdata_q;
  assign boot_ack     = (state_q == S_DONE) && (owner_q == OWN_BOOT);
  assign inst_ack     = (state_q == S_DONE) && (owner_q == OWN_INST);
  assign data_ack     = (state_q == S_DONE) && (owner_q == OWN_DATA);
  assign inst_rd_data = inst_rd_q;
  assign data_rd_data = data_rd_q;
  assign busy         = (state_q != S_IDLE);

`ifdef MEM_ARB_STATS_EN
  logic [15:0] inst_cnt_q, data_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_cnt_q <= '0;
      data_cnt_q <= '0;
    end else begin
      if ((state_q == S_ISSUE) && (owner_q == OWN_INST)) inst_cnt_q <= sat_inc16(inst_cnt_q);
      if ((state_q == S_ISSUE) && (owner_q == OWN_DATA)) data_cnt_q <= sat_inc16(data_cnt_q);
    end
  end

  assign inst_grant_cnt = inst_cnt_q;
  assign data_grant_cnt = data_cnt_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (ACCESS_CYCLES=2): directed vectors,
// multi-cycle corner sequences and a randomized run against a transaction model.
module tb_mem_arbiter;

  localparam int AC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        boot_mode, boot_req, boot_ack;
  logic [19:0] boot_addr;
  logic [31:0] boot_wr_data;
  logic        inst_req, inst_ack;
  logic [19:0] inst_addr;
  logic [31:0] inst_rd_data;
  logic        data_req, data_wr_en, data_ack;
  logic [19:0] data_addr;
  logic [31:0] data_wr_data, data_rd_data;
  logic        mem_rd_en, mem_wr_en, busy;
  logic [19:0] mem_addr;
  logic [31:0] mem_wr_data, mem_rd_data;
`ifdef MEM_ARB_STATS_EN
  logic [15:0] igc, dgc;
`endif

  logic        rd_ovr_en = 1'b0;
  logic [31:0] rd_ovr    = '0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] fmem(input logic [19:0] a);
    return {a[7:0], a ^ 20'h5A5A5, 4'hC};
  endfunction

  // SRAM stand-in: read data is a fixed function of the presented address
  assign mem_rd_data = rd_ovr_en ? rd_ovr : fmem(mem_addr);

  mem_arbiter #(
    .DATA_WIDTH   (32),
    .ADDR_WIDTH   (20),
    .ACCESS_CYCLES(AC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .boot_mode    (boot_mode),
    .boot_req     (boot_req),
    .boot_addr    (boot_addr),
    .boot_wr_data (boot_wr_data),
    .boot_ack     (boot_ack),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_rd_data (inst_rd_data),
    .inst_ack     (inst_ack),
    .data_req     (data_req),
    .data_wr_en   (data_wr_en),
    .data_addr    (data_addr),
    .data_wr_data (data_wr_data),
    .data_rd_data (data_rd_data),
    .data_ack     (data_ack),
    .mem_rd_en    (mem_rd_en),
    .mem_wr_en    (mem_wr_en),
    .mem_addr     (mem_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_rd_data  (mem_rd_data),
    .busy         (busy)
`ifdef MEM_ARB_STATS_EN
    ,
    .inst_grant_cnt(igc),
    .data_grant_cnt(dgc)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drop_all();
    boot_req = 1'b0;
    inst_req = 1'b0;
    data_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drop_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  int          w_rd, w_wr, w_stb_at, w_ab, w_ai, w_ad, w_ack_at, w_busy;
  logic [19:0] w_addr;
  logic [31:0] w_wdata;

  task automatic watch(input int n, input bit auto_drop);
    w_rd = 0; w_wr = 0; w_ab = 0; w_ai = 0; w_ad = 0; w_busy = 0;
    w_stb_at = -1; w_ack_at = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (mem_rd_en || mem_wr_en) begin
        if (w_stb_at < 0) w_stb_at = i;
        w_addr  = mem_addr;
        w_wdata = mem_wr_data;
      end
      if (mem_rd_en) w_rd++;
      if (mem_wr_en) w_wr++;
      if ((boot_ack || inst_ack || data_ack) && (w_ack_at < 0)) w_ack_at = i;
      if (boot_ack) begin w_ab++; if (auto_drop) boot_req = 1'b0; end
      if (inst_ack) begin w_ai++; if (auto_drop) inst_req = 1'b0; end
      if (data_ack) begin w_ad++; if (auto_drop) data_req = 1'b0; end
      if (busy) w_busy++;
    end
  endtask

  typedef struct {
    bit          bm, b, i, d, we;
    logic [19:0] addr;
    logic [31:0] wd, rdv;
    int          exp_rd, exp_wr, exp_port;  // port: 0 none, 1 boot, 2 inst, 3 data
    logic [31:0] exp_rdd;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[7];
    int          k, g, e;
    int          free_at, stb_at, ack_at, own;
    bit          ewe, es, pb, pi, pd, pref_d;
    logic [19:0] eaddr;
    logic [31:0] ewd, last_i, last_d;

    vt[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 20'h00010, 32'hDEADBEEF, 32'h0,        0, 1, 1, 32'h0};
    vt[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 20'h00004, 32'h0,        32'h20010005, 1, 0, 2, 32'h20010005};
    vt[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 20'hABCDE, 32'h12345678, 32'h0,        0, 1, 3, 32'h0};
    vt[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 20'hFFFFF, 32'h0,        32'hCAFEF00D, 1, 0, 3, 32'hCAFEF00D};
    vt[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00001, 32'h11111111, 32'h0,        0, 0, 0, 32'h0};
    vt[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 20'h00002, 32'h0,        32'h0,        0, 0, 0, 32'h0};
    vt[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 20'h00040, 32'h0,        32'h55AA55AA, 1, 0, 2, 32'h55AA55AA};

    rst = 1'b1; boot_mode = 1'b0; drop_all();
    boot_addr = '0; boot_wr_data = '0; inst_addr = '0;
    data_wr_en = 1'b0; data_addr = '0; data_wr_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {mem_rd_en, mem_wr_en}, 0);
    chk("rst_acks", {boot_ack, inst_ack, data_ack}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wr_data, 0);
    chk("rst_rd_data", {inst_rd_data, data_rd_data}, 0);
    rst = 1'b0;

    // directed single-transaction vectors
    for (int v = 0; v < 7; v++) begin
      boot_mode = vt[v].bm;
      boot_req = vt[v].b; boot_addr = vt[v].addr; boot_wr_data = vt[v].wd;
      inst_req = vt[v].i; inst_addr = vt[v].addr;
      data_req = vt[v].d; data_wr_en = vt[v].we; data_addr = vt[v].addr; data_wr_data = vt[v].wd;
      rd_ovr_en = (vt[v].rdv != 0); rd_ovr = vt[v].rdv;
      watch(AC + 3, 1'b1);
      drop_all();
      chk($sformatf("v%0d_rd_cnt", v), w_rd, vt[v].exp_rd);
      chk($sformatf("v%0d_wr_cnt", v), w_wr, vt[v].exp_wr);
      chk($sformatf("v%0d_boot_ack", v), w_ab, vt[v].exp_port == 1);
      chk($sformatf("v%0d_inst_ack", v), w_ai, vt[v].exp_port == 2);
      chk($sformatf("v%0d_data_ack", v), w_ad, vt[v].exp_port == 3);
      chk($sformatf("v%0d_busy_cyc", v), w_busy, (vt[v].exp_port != 0) ? AC + 2 : 0);
      if (vt[v].exp_port != 0) begin
        chk($sformatf("v%0d_stb_at", v), w_stb_at, 0);
        chk($sformatf("v%0d_ack_at", v), w_ack_at, AC + 1);
        chk($sformatf("v%0d_addr", v), w_addr, vt[v].addr);
        if (vt[v].exp_wr != 0) chk($sformatf("v%0d_wdata", v), w_wdata, vt[v].wd);
        if (vt[v].exp_port == 2) chk($sformatf("v%0d_inst_rd", v), inst_rd_data, vt[v].exp_rdd);
        if (vt[v].exp_port == 3 && vt[v].exp_rd != 0)
          chk($sformatf("v%0d_data_rd", v), data_rd_data, vt[v].exp_rdd);
      end
    end
    rd_ovr_en = 1'b0;

    // inst and data held high from reset: data, inst, data, inst every AC+3 cycles
    @(negedge clk);
    rst = 1'b1; boot_mode = 1'b0;
    inst_req = 1'b1; inst_addr = 20'h00100;
    data_req = 1'b1; data_wr_en = 1'b0; data_addr = 20'h00200;
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (inst_ack || data_ack) begin
        chk($sformatf("rr_port%0d", k), data_ack ? 3 : 2, (k % 2 == 0) ? 3 : 2);
        chk($sformatf("rr_when%0d", k), i, AC + 1 + (AC + 3) * k);
        k++;
      end
    end
    drop_all();
    chk("rr_ack_count", k, 4);
    chk("rr_inst_rd", inst_rd_data, fmem(20'h00100));
    chk("rr_data_rd", data_rd_data, fmem(20'h00200));

    // reset while in WAIT aborts the access
    data_req = 1'b1; data_wr_en = 1'b0; data_addr = 20'h00123;
    @(negedge clk);
    chk("abort_strobe", mem_rd_en, 1);
    @(negedge clk);
    rst = 1'b1; data_req = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_ack", data_ack, 0);
    rst = 1'b0;
    watch(8, 1'b0);
    chk("abort_no_strobe", w_rd + w_wr, 0);
    chk("abort_no_ack", w_ab + w_ai + w_ad, 0);
    data_req = 1'b1; data_addr = 20'h00777;
    watch(AC + 3, 1'b1);
    drop_all();
    chk("fresh_rd_cnt", w_rd, 1);
    chk("fresh_ack_at", w_ack_at, AC + 1);
    chk("fresh_data_ack", w_ad, 1);
    chk("fresh_rd_data", data_rd_data, fmem(20'h00777));

    // boot_req outside boot mode is ignored
    boot_mode = 1'b0; boot_req = 1'b1; boot_addr = 20'h00005;
    watch(20, 1'b0);
    drop_all();
    chk("noboot_strobes", w_rd + w_wr, 0);
    chk("noboot_ack", w_ab, 0);
    chk("noboot_busy", w_busy, 0);

    // mode change and req drop during a transaction: access still completes
    boot_mode = 1'b1; boot_req = 1'b1; boot_addr = 20'h00ABC; boot_wr_data = 32'h0BADF00D;
    @(negedge clk);
    chk("mchg_wr_en", mem_wr_en, 1);
    chk("mchg_wdata", mem_wr_data, 32'h0BADF00D);
    boot_mode = 1'b0; boot_req = 1'b0;
    watch(4, 1'b0);
    chk("mchg_boot_ack", w_ab, 1);
    chk("mchg_ack_at", w_ack_at, AC);
    chk("mchg_no_more", w_rd + w_wr, 0);
    inst_req = 1'b1; inst_addr = 20'h00321;
    @(negedge clk);
    chk("idrop_rd_en", mem_rd_en, 1);
    inst_req = 1'b0;
    watch(4, 1'b0);
    chk("idrop_inst_ack", w_ai, 1);
    chk("idrop_ack_at", w_ack_at, AC);
    chk("idrop_rd_data", inst_rd_data, fmem(20'h00321));

`ifdef MEM_ARB_STATS_EN
    do_reset();
    boot_mode = 1'b0;
    for (int j = 0; j < 3; j++) begin
      data_req = 1'b1; data_wr_en = 1'b1; data_addr = 20'(j);
      watch(AC + 3, 1'b1);
      drop_all();
    end
    chk("stats_data3", dgc, 3);
    chk("stats_inst0", igc, 0);
    force dut.data_cnt_q = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.data_cnt_q;
    @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      data_req = 1'b1; data_wr_en = 1'b1; data_addr = 20'(j);
      watch(AC + 3, 1'b1);
      drop_all();
    end
    chk("stats_saturate", dgc, 16'hFFFF);
`endif

    // randomized traffic against a transaction-level model
    boot_mode = 1'b0;
    do_reset();
    free_at = 1; stb_at = -100; ack_at = -100; own = 0;
    ewe = 1'b0; eaddr = '0; ewd = '0;
    pb = 1'b0; pi = 1'b0; pd = 1'b0; pref_d = 1'b1;
    last_i = '0; last_d = '0;
    for (int c = 0; c < 2400; c++) begin
      if (c > 0) @(negedge clk);
      es = (c == stb_at);
      chk("r_rd_en", mem_rd_en, es && !ewe);
      chk("r_wr_en", mem_wr_en, es && ewe);
      if (es) begin
        chk("r_addr", mem_addr, eaddr);
        if (ewe) chk("r_wdata", mem_wr_data, ewd);
      end
      chk("r_busy", busy, (c >= stb_at) && (c <= ack_at));
      chk("r_boot_ack", boot_ack, (c == ack_at) && (own == 1));
      chk("r_inst_ack", inst_ack, (c == ack_at) && (own == 2));
      chk("r_data_ack", data_ack, (c == ack_at) && (own == 3));
      if (c == ack_at) begin
        if (!ewe && own == 2) last_i = fmem(eaddr);
        if (!ewe && own == 3) last_d = fmem(eaddr);
        case (own)
          1: begin pb = 1'b0; boot_req = 1'b0; end
          2: begin pi = 1'b0; inst_req = 1'b0; end
          default: begin pd = 1'b0; data_req = 1'b0; end
        endcase
      end
      chk("r_inst_rd", inst_rd_data, last_i);
      chk("r_data_rd", data_rd_data, last_d);

      if ((c % 300) == 299 && c > ack_at) begin
        boot_mode = ~boot_mode;
        pb = 1'b0; pi = 1'b0; pd = 1'b0;
        drop_all();
      end
      if ((c % 300) < 240 && c != ack_at) begin
        if (!pi && $urandom_range(3) == 0) begin
          pi = 1'b1; inst_req = 1'b1; inst_addr = 20'($urandom);
        end
        if (!pd && $urandom_range(3) == 0) begin
          pd = 1'b1; data_req = 1'b1; data_wr_en = 1'($urandom_range(1));
          data_addr = 20'($urandom); data_wr_data = $urandom;
        end
        if (!pb && $urandom_range(5) == 0) begin
          pb = 1'b1; boot_req = 1'b1; boot_addr = 20'($urandom); boot_wr_data = $urandom;
        end
      end

      e = c + 1;
      if (e >= free_at) begin
        g = 0;
        if (boot_mode) begin
          if (pb) g = 1;
        end else if (pi && pd) g = pref_d ? 3 : 2;
        else if (pd) g = 3;
        else if (pi) g = 2;
        if (g != 0) begin
          own = g; stb_at = e; ack_at = e + 1 + AC; free_at = e + AC + 3;
          case (g)
            1: begin ewe = 1'b1; eaddr = boot_addr; ewd = boot_wr_data; end
            2: begin ewe = 1'b0; eaddr = inst_addr; end
            default: begin ewe = data_wr_en; eaddr = data_addr; ewd = data_wr_data; end
          endcase
          if (g > 1) pref_d = (g == 2);
        end
      end
    end
    drop_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
